ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
- Microcode-style control sequencer for the 8-bit CPU model.
- Steps each instruction through a fixed T-state pipeline. Drives the load enables (EN) and bus-source select that feed the 8-bit register stages: MAR, IR, A, B, OUT.
- Sits directly upstream of those registers; consumes the IR contents and the ALU zero flag.

Parameters:
- DW, 8, data/instruction width; opcode is IR[DW-1:DW-4], operand is IR[DW-5:0].
- NSTEP, 5, number of T-states per instruction, T0..T4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = allow a new instruction to start at T0; 0 = stall at T0.
- ir  in  DW  current IR register contents.
- zero  in  1  ALU result == 0 flag, valid combinationally.
- bus_sel  out  3  bus source: 0 NONE, 1 PC, 2 MEM, 3 IR operand, 4 ALU, 5 A.
- mar_ld  out  1  MAR load enable.
- ir_ld  out  1  IR load enable.
- a_ld  out  1  A load enable.
- b_ld  out  1  B load enable.
- out_ld  out  1  output register load enable.
- mem_we  out  1  RAM write enable.
- pc_inc  out  1  PC increment.
- pc_ld  out  1  PC load from bus.
- alu_sub  out  1  ALU subtract select.
- halted  out  1  sequencer halted.
- step  out  3  current T-state, for debug display.

Behaviour:
- State: step register 0..NSTEP-1, plus halted flag. No other storage.
- Reset (rst=1, async):
  - step=0, halted=0.
  - All enables 0 and bus_sel=0 for as long as rst is high.
- Output timing:
  - All outputs are combinational decode of (step, halted, ir, zero, run). Moore-like with respect to step.
  - Enables are asserted for exactly one cycle and sampled by downstream registers on the next posedge.
- Fetch (opcode-independent):
  - T0: if run=1 → bus_sel=PC, mar_ld=1. If run=0 → all outputs 0 and step holds at 0.
  - T1: bus_sel=MEM, ir_ld=1, pc_inc=1.
- Execute, T2..T4 (step values not listed are idle, outputs 0):
  - 0 NOP: done at T2.
  - 1 LDA: T2 IR→MAR; T3 MEM→A; done.
  - 2 ADD: T2 IR→MAR; T3 MEM→B; T4 ALU→A, alu_sub=0; done.
  - 3 SUB: as ADD, but alu_sub=1 at T3 and T4.
  - 4 STA: T2 IR→MAR; T3 bus_sel=A, mem_we=1; done.
  - 5 LDI: T2 IR→A; done.
  - 6 JMP: T2 IR→pc_ld; done.
  - 7 JZ: T2 pc_ld=zero, bus_sel=IR; done regardless of zero.
  - 14 OUT: T2 bus_sel=A, out_ld=1; done.
  - 15 HLT: T2 sets halted=1 at the posedge; step→0.
  - 8..13 undefined: treated as NOP.
- Step advance:
  - On "done", step→0 at the next posedge; otherwise step+1.
  - step never exceeds NSTEP-1. Reaching T4 always forces step→0.
- Halted: halted=1 forces all enables 0 and step=0. Held until rst; run is ignored.
- run deassert: only sampled at T0. A mid-instruction run=0 does not stall the current instruction.
- Reset mid-instruction: aborts immediately; no partial enable persists after rst rises.
- Mutual exclusion: at most one bus source per cycle. pc_inc and pc_ld never both 1.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOP..OP_HLT.
  - bus_sel encodings: BUS_NONE, BUS_PC, BUS_MEM, BUS_IR, BUS_ALU, BUS_A.
  - T-state constants T0..T4.
- One sub-module: ctrl_decode. Purely combinational; maps (opcode, step, zero) to enables, bus_sel and a done flag.
- The top holds the step/halted registers, run/halt gating and reset forcing.

Test Plan:
- Reset: rst=1 mid-T3 of ADD → step=0, all enables 0, bus_sel=0 within the same cycle. After release, T0 shows mar_ld=1, bus_sel=1.
- LDI: ir=0x57, run=1 → steps T0,T1,T2 with a_ld=1, bus_sel=3 at T2; next cycle step=0. Instruction takes 3 cycles.
- ADD: ir=0x2A →
  - T2: mar_ld, bus_sel=3.
  - T3: b_ld, bus_sel=2.
  - T4: a_ld, bus_sel=4, alu_sub=0.
  - Then step=0.
  - Same sequence for SUB (ir=0x3A) with alu_sub=1 at T3 and T4.
- JZ: ir=0x7C, zero=1 → pc_ld=1 at T2. Repeat with zero=0 → pc_ld=0. Both cases return to T0 after T2.
- HLT: ir=0xF0 → halted=1 after T2. Then toggling run for 10 cycles keeps step=0 and all enables 0, until rst pulses; halted=0 after reset.
- Stall: run=0 at T0 for 4 cycles → step stays 0, outputs 0. run=1 → mar_ld=1 the same cycle. A run drop at T2 of LDA still completes a_ld at T3.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// rtl/ctrl_sequencer_pkg.sv - shared constants and control-word type for the T-state sequencer
package ctrl_sequencer_pkg;

    localparam int CTRL_DW    = 8;
    localparam int CTRL_NSTEP = 5;

    // Opcodes carried in IR[DW-1:DW-4]
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JZ  = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Bus source select encodings
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_MEM  = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd3;
    localparam logic [2:0] BUS_ALU  = 3'd4;
    localparam logic [2:0] BUS_A    = 3'd5;

    // T-states
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // One microcode word: everything the decoder produces for a single T-state.
    // done ends the instruction at the next edge; halt latches the halted flag.
    typedef struct packed {
        logic [2:0] bus_sel;
        logic       mar_ld;
        logic       ir_ld;
        logic       a_ld;
        logic       b_ld;
        logic       out_ld;
        logic       mem_we;
        logic       pc_inc;
        logic       pc_ld;
        logic       alu_sub;
        logic       done;
        logic       halt;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational microcode decode of (opcode, step, zero)
module ctrl_decode
    import ctrl_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] step,
    input  logic       zero,
    output ctrl_t      ctrl
);

    // Fetch is opcode independent; execute words per opcode, unlisted slots idle and done
    always_comb begin
        ctrl = CTRL_IDLE;
        case (step)
            T0: begin
                ctrl.bus_sel = BUS_PC;
                ctrl.mar_ld  = 1'b1;
            end
            T1: begin
                ctrl.bus_sel = BUS_MEM;
                ctrl.ir_ld   = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.bus_sel = BUS_IR;
                        ctrl.mar_ld  = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.bus_sel = BUS_IR;
                        ctrl.a_ld    = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.bus_sel = BUS_IR;
                        ctrl.pc_ld   = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_JZ: begin
                        // Bus still carries the operand; only the load is conditional
                        ctrl.bus_sel = BUS_IR;
                        ctrl.pc_ld   = zero;
                        ctrl.done    = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.out_ld  = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl.halt = 1'b1;
                        ctrl.done = 1'b1;
                    end
                    default: begin
                        // NOP and the undefined opcodes 8..13
                        ctrl.done = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.bus_sel = BUS_MEM;
                        ctrl.a_ld    = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.bus_sel = BUS_MEM;
                        ctrl.b_ld    = 1'b1;
                        ctrl.alu_sub = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.mem_we  = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                    default: begin
                        ctrl.done = 1'b1;
                    end
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.bus_sel = BUS_ALU;
                    ctrl.a_ld    = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
                ctrl.done = 1'b1;
            end
            default: begin
                ctrl.done = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - T-state control sequencer top: step/halted state, run and halt gating
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int DW    = CTRL_DW,
    parameter int NSTEP = CTRL_NSTEP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [DW-1:0] ir,
    input  logic          zero,
    output logic [2:0]    bus_sel,
    output logic          mar_ld,
    output logic          ir_ld,
    output logic          a_ld,
    output logic          b_ld,
    output logic          out_ld,
    output logic          mem_we,
    output logic          pc_inc,
    output logic          pc_ld,
    output logic          alu_sub,
    output logic          halted,
    output logic [2:0]    step
);

    logic [2:0] step_q;
    logic [2:0] step_d;
    logic       halted_q;
    logic       halted_d;
    logic       idle;
    ctrl_t      dec;

    // Operand bits are routed to the datapath over the bus, not decoded here
    logic unused_operand;
    assign unused_operand = ^ir[DW-5:0];

    ctrl_decode u_decode (
        .opcode (ir[DW-1:DW-4]),
        .step   (step_q),
        .zero   (zero),
        .ctrl   (dec)
    );

    // Next step and halted flag; run only matters while waiting at T0
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (halted_q) begin
            step_d = T0;
        end else if (step_q == T0 && !run) begin
            step_d = T0;
        end else begin
            if (dec.done || step_q >= 3'(NSTEP - 1)) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
            if (dec.halt) begin
                halted_d = 1'b1;
            end
        end
    end

    // Quiet every output during reset, after halt, and while stalled at T0
    always_comb begin
        idle = rst || halted_q || (step_q == T0 && !run);
    end

    assign bus_sel = idle ? BUS_NONE : dec.bus_sel;
    assign mar_ld  = dec.mar_ld  & ~idle;
    assign ir_ld   = dec.ir_ld   & ~idle;
    assign a_ld    = dec.a_ld    & ~idle;
    assign b_ld    = dec.b_ld    & ~idle;
    assign out_ld  = dec.out_ld  & ~idle;
    assign mem_we  = dec.mem_we  & ~idle;
    assign pc_inc  = dec.pc_inc  & ~idle;
    assign pc_ld   = dec.pc_ld   & ~idle;
    assign alu_sub = dec.alu_sub & ~idle;
    assign halted  = halted_q;
    assign step    = step_q;

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

endmodule
